// File: rtl/nextasic_pkg.sv
// Shared definitions for the NeXT ASIC link (receiver and Sender).
package nextasic_pkg;

  // Payload width shared by Sender and receiver
  localparam int DEFAULT_DATA_WIDTH = 40;

  // Start bit + payload + stop bit
  localparam int FRAME_BITS = DEFAULT_DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/receiver_bit_sync.sv
// N-flop synchronizer with a reset value of 1, for idle-high inbound link lines.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/receiver.sv
// Serial-to-parallel receive stage: deframes start/payload/stop words from the
// NeXT host line and presents them through a one-entry valid/ready holding register.
module receiver
  import nextasic_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sin,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                  s;
  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         cnt;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sin),
    .q    (s)
  );

  // Frame FSM, shift register, bit counter and holding register with registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift         <= '0;
      cnt           <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      overrun       <= 1'b0;
      framing_error <= 1'b0;

      // Consumer handshake; a same-edge load below overrides the clear
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!s) begin
            state <= DATA;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shift <= {shift[DATA_WIDTH-2:0], s};
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            cnt   <= CW'(DATA_WIDTH);
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          busy <= 1'b0;
          if (s) begin
            state <= IDLE;
            if (!data_valid || data_ready) begin
              data       <= shift;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            framing_error <= 1'b1;
            state         <= BREAK;
          end
        end
        BREAK: begin
          if (s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed, table-driven bench for receiver with hand-written multi-cycle sequences.
module tb_receiver;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [39:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        overrun;
  logic        framing_error;
  logic        busy;

  int unsigned pass_cnt;
  int unsigned total_cnt;
  int unsigned cyc;
  int unsigned ovr_pulses;
  int unsigned fe_pulses;

  logic [39:0] acc_word[$];
  int unsigned acc_cyc[$];

  receiver #(
    .DATA_WIDTH (40),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sin          (sin),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .overrun      (overrun),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and flag pulses mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid && data_ready) begin
        acc_word.push_back(data);
        acc_cyc.push_back(cyc);
      end
      if (overrun) ovr_pulses++;
      if (framing_error) fe_pulses++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Drive the first nbits of a frame (start, payload MSB first, stop), one per cycle
  task automatic send_frame(input logic [39:0] w, input logic stop, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      if (i == 0) sin = 1'b0;
      else if (i <= 40) sin = w[40-i];
      else sin = stop;
      tick();
    end
  endtask

  task automatic clear_monitors();
    acc_word.delete();
    acc_cyc.delete();
    ovr_pulses = 0;
    fe_pulses  = 0;
  endtask

  typedef struct {
    logic [39:0] payload;
    logic        stop;
    logic        exp_valid;
    logic [39:0] exp_data;
    logic        exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    cyc        = 0;
    ovr_pulses = 0;
    fe_pulses  = 0;
    sin        = 1'b1;
    data_ready = 1'b0;
    rst_n      = 1'b0;

    vecs[0] = '{40'hD999999991, 1'b1, 1'b1, 40'hD999999991, 1'b0};
    vecs[1] = '{40'h0000000000, 1'b1, 1'b1, 40'h0000000000, 1'b0};
    vecs[2] = '{40'hFFFFFFFFFF, 1'b1, 1'b1, 40'hFFFFFFFFFF, 1'b0};
    vecs[3] = '{40'h8000000001, 1'b1, 1'b1, 40'h8000000001, 1'b0};
    vecs[4] = '{40'h123456789A, 1'b0, 1'b0, 40'h0000000000, 1'b1};
    vecs[5] = '{40'hA5A5A5A5A5, 1'b1, 1'b1, 40'hA5A5A5A5A5, 1'b0};

    // Reset state
    ticks(3);
    check("reset_data", {24'h0, data}, 64'h0);
    check("reset_valid", {63'h0, data_valid}, 64'h0);
    check("reset_flags", {61'h0, overrun, framing_error, busy}, 64'h0);
    rst_n = 1'b1;
    ticks(3);
    clear_monitors();

    // Table-driven single frames, each checked at the predicted edges then drained
    for (int v = 0; v < 6; v++) begin
      data_ready = 1'b0;
      send_frame(vecs[v].payload, vecs[v].stop, 42);
      sin = 1'b1;
      tick();  // in STOP, stop bit not yet sampled
      check($sformatf("v%0d_pre_valid", v), {63'h0, data_valid}, 64'h0);
      check($sformatf("v%0d_busy_stop", v), {63'h0, busy}, 64'h1);
      tick();  // stop-sample edge
      check($sformatf("v%0d_valid", v), {63'h0, data_valid}, {63'h0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) check($sformatf("v%0d_data", v), {24'h0, data}, {24'h0, vecs[v].exp_data});
      check($sformatf("v%0d_fe", v), {63'h0, framing_error}, {63'h0, vecs[v].exp_fe});
      check($sformatf("v%0d_ovr", v), {63'h0, overrun}, 64'h0);
      check($sformatf("v%0d_busy_after", v), {63'h0, busy}, 64'h0);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check($sformatf("v%0d_drained", v), {63'h0, data_valid}, 64'h0);
      check($sformatf("v%0d_flags_clear", v), {62'h0, overrun, framing_error}, 64'h0);
      ticks(2);
    end
    check("table_fe_pulses", 64'(fe_pulses), 64'd1);
    check("table_ovr_pulses", 64'(ovr_pulses), 64'd0);

    // Back-to-back frames with data_ready tied high
    clear_monitors();
    data_ready = 1'b1;
    send_frame(40'hD999999991, 1'b1, 42);
    send_frame(40'hD999999993, 1'b1, 42);
    send_frame(40'hD999999997, 1'b1, 42);
    sin = 1'b1;
    ticks(5);
    data_ready = 1'b0;
    check("b2b_count", 64'(acc_word.size()), 64'd3);
    if (acc_word.size() == 3) begin
      check("b2b_w0", {24'h0, acc_word[0]}, 64'hD999999991);
      check("b2b_w1", {24'h0, acc_word[1]}, 64'hD999999993);
      check("b2b_w2", {24'h0, acc_word[2]}, 64'hD999999997);
      check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd42);
      check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd42);
    end
    check("b2b_flags", 64'(ovr_pulses + fe_pulses), 64'd0);

    // Overrun: second frame dropped while the first is held
    clear_monitors();
    data_ready = 1'b0;
    send_frame(40'h1111111111, 1'b1, 42);
    send_frame(40'h2222222222, 1'b1, 42);
    sin = 1'b1;
    tick();
    check("ovr_pre", {63'h0, overrun}, 64'h0);
    tick();  // stop-sample edge of the second frame
    check("ovr_pulse", {63'h0, overrun}, 64'h1);
    check("ovr_held", {24'h0, data}, 64'h1111111111);
    tick();
    check("ovr_pulse_end", {63'h0, overrun}, 64'h0);
    data_ready = 1'b1;
    ticks(3);
    data_ready = 1'b0;
    check("ovr_count", 64'(ovr_pulses), 64'd1);
    check("ovr_accepts", 64'(acc_word.size()), 64'd1);
    if (acc_word.size() == 1) check("ovr_first_word", {24'h0, acc_word[0]}, 64'h1111111111);
    check("ovr_empty", {63'h0, data_valid}, 64'h0);

    // Simultaneous accept and load on the stop-sample edge
    clear_monitors();
    data_ready = 1'b0;
    send_frame(40'h3333333333, 1'b1, 42);
    send_frame(40'h4444444444, 1'b1, 42);
    sin = 1'b1;
    check("sim_held_a", {63'h0, data_valid}, 64'h1);
    tick();
    data_ready = 1'b1;
    tick();  // stop-sample edge: A consumed, B loaded
    data_ready = 1'b0;
    check("sim_valid_kept", {63'h0, data_valid}, 64'h1);
    check("sim_data_b", {24'h0, data}, 64'h4444444444);
    check("sim_no_ovr", {63'h0, overrun}, 64'h0);
    tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("sim_count", 64'(acc_word.size()), 64'd2);
    if (acc_word.size() == 2) begin
      check("sim_w0", {24'h0, acc_word[0]}, 64'h3333333333);
      check("sim_w1", {24'h0, acc_word[1]}, 64'h4444444444);
    end
    check("sim_ovr_count", 64'(ovr_pulses), 64'd0);

    // Framing error followed by a line held low
    clear_monitors();
    send_frame(40'h5555555555, 1'b0, 42);
    sin = 1'b0;
    ticks(10);
    check("fe_break_busy", {63'h0, busy}, 64'h0);
    check("fe_no_valid", {63'h0, data_valid}, 64'h0);
    check("fe_count", 64'(fe_pulses), 64'd1);
    sin = 1'b1;
    ticks(4);
    check("fe_no_false_start", {63'h0, busy}, 64'h0);
    send_frame(40'h6666666666, 1'b1, 42);
    sin = 1'b1;
    ticks(2);
    check("fe_next_valid", {63'h0, data_valid}, 64'h1);
    check("fe_next_data", {24'h0, data}, 64'h6666666666);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;

    // Reset in the middle of a frame, with a word still held
    send_frame(40'h7777777777, 1'b1, 42);
    sin = 1'b1;
    ticks(3);
    send_frame(40'h9999999999, 1'b1, 21);
    check("rst_pre_busy", {63'h0, busy}, 64'h1);
    check("rst_pre_valid", {63'h0, data_valid}, 64'h1);
    rst_n = 1'b0;
    sin   = 1'b1;
    #1;
    check("rst_async_data", {24'h0, data}, 64'h0);
    check("rst_async_outs", {60'h0, data_valid, overrun, framing_error, busy}, 64'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    clear_monitors();
    send_frame(40'hC3C3C3C3C3, 1'b1, 42);
    ticks(2);
    check("rst_after_valid", {63'h0, data_valid}, 64'h1);
    check("rst_after_data", {24'h0, data}, 64'hC3C3C3C3C3);
    check("rst_after_flags", 64'(ovr_pulses + fe_pulses), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
